// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM state, the bundled pipeline
// control word and the x0 register id.
package common;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } hz_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// CNT_W-wide up counter with enable and synchronous reset; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze > branch flush > load-use stall,
// plus stall/flush performance counters and a sticky memory-timeout flag.
module hazard_ctrl
  import common::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_id,
  input  logic [4:0]       id_rs2_id,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_id,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t   state;
  logic [WAIT_W-1:0] wait_cnt;
  hz_ctrl_t    ctrl;
  logic        load_use, mem_stall;

  assign load_use  = ex_mem_read && (ex_rd_id != REG_ZERO) &&
                     ((id_uses_rs1 && ex_rd_id == id_rs1_id) ||
                      (id_uses_rs2 && ex_rd_id == id_rs2_id));
  assign mem_stall = mem_req && !mem_ready;

  // Priority decode; the wait state only drives the timeout, not the controls,
  // since a stalled access freezes the pipe from whichever state it starts in.
  always_comb begin
    ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
             id_ex_bubble: 1'b0, pipe_hold: 1'b0};
    if (reset) begin
      ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
               id_ex_bubble: 1'b1, pipe_hold: 1'b0};
    end else if (mem_stall) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wait_cnt == WAIT_MAX) timeout_err <= 1'b1;
      case (state)
        RUN: if (mem_stall) state <= MEM_WAIT;
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .en(!reset && !ctrl.pc_write), .cnt(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .en(!reset && ctrl.if_id_flush), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1_id, id_rs2_id, ex_rd_id;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int  m_stall, m_flush, m_wait_n;
  bit  m_err, m_in_wait;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_id(ex_rd_id),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit rst, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit ld, input int rd, input bit br, input bit req, input bit rdy);
    reset = rst; id_rs1_id = 5'(rs1); id_rs2_id = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; ex_mem_read = ld; ex_rd_id = 5'(rd);
    ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit stall, lu;
    logic [4:0] exp_ctrl;
    @(negedge clk);
    stall = mem_req && !mem_ready;
    lu = ex_mem_read && ex_rd_id != 0 &&
         ((id_uses_rs1 && id_rs1_id == ex_rd_id) || (id_uses_rs2 && id_rs2_id == ex_rd_id));
    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
    if (reset)                exp_ctrl = 5'b00110;
    else if (stall)           exp_ctrl = 5'b00001;
    else if (ex_branch_taken) exp_ctrl = 5'b11110;
    else if (lu)              exp_ctrl = 5'b00010;
    else                      exp_ctrl = 5'b11000;
    chk("ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}, {27'd0, exp_ctrl});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
    chk("stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, m_stall);
    chk("flush_cnt", {{(32-CNT_W){1'b0}}, flush_cnt}, m_flush);
    if (reset) begin
      m_stall = 0; m_flush = 0; m_wait_n = 0; m_err = 0; m_in_wait = 0;
    end else begin
      if (!exp_ctrl[4] && m_stall < CMAX) m_stall++;
      if (exp_ctrl[2] && m_flush < CMAX) m_flush++;
      // wait_n: memory-wait cycles already spent after the entry cycle
      if (m_in_wait && m_wait_n >= TO) m_err = 1;
      if (m_in_wait && stall) m_wait_n++;
      else m_wait_n = 0;
      m_in_wait = stall;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int hold;
    m_stall = 0; m_flush = 0; m_wait_n = 0; m_err = 0; m_in_wait = 0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    cycle(); cycle();

    // load-use on rs1: exactly one stall cycle, then defaults
    set_in(0, 5, 1, 1, 1, 1, 5, 0, 0, 1); cycle();
    chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    set_in(0, 5, 1, 1, 1, 0, 0, 0, 0, 1); cycle();

    // x0 destination and unused rs2 operand: no stall
    set_in(0, 0, 0, 1, 1, 1, 0, 0, 0, 1); cycle();
    set_in(0, 3, 7, 1, 0, 1, 7, 0, 0, 1); cycle();
    chk("nostall_cnt", {28'd0, stall_cnt}, 32'd1);

    // branch with coincident load-use: flush wins
    set_in(0, 6, 2, 1, 1, 1, 6, 1, 0, 1); cycle();
    chk("br_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    chk("br_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // memory wait for 3 cycles with a branch pending, then ready
    for (int i = 0; i < 3; i++) begin set_in(0, 1, 2, 1, 1, 0, 0, 1, 1, 0); cycle(); end
    set_in(0, 1, 2, 1, 1, 0, 0, 1, 1, 1); cycle();
    chk("mw_stall_cnt", {28'd0, stall_cnt}, 32'd4);
    chk("mw_flush_cnt", {28'd0, flush_cnt}, 32'd2);

    // timeout: long stall, flag sticks after ready returns
    for (int i = 0; i < TO + 4; i++) begin set_in(0, 1, 2, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    set_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);

    // reset in the middle of a wait
    set_in(0, 1, 2, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle();
    set_in(1, 1, 2, 0, 0, 0, 0, 1, 1, 0); cycle();
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    set_in(0, 1, 2, 0, 0, 0, 0, 0, 0, 1); cycle();

    // randomized traffic: small register ids for frequent matches, occasional long waits
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      bit req, rdy;
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = $urandom_range(2, 2 * TO + 3);
      req = (hold > 0) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      rdy = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (hold > 0) hold--;
      set_in($urandom_range(0, 99) < 2, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 4) == 0, req, rdy);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
